// File: rtl/fft_out_serializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_out_serializer_pkg: shared types for the FFT output pair serializer.
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_out_serializer_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] re0;
        logic [DATA_W_DEFAULT-1:0] im0;
        logic [DATA_W_DEFAULT-1:0] re1;
        logic [DATA_W_DEFAULT-1:0] im1;
    } pair_t;

    typedef enum logic [0:0] {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

endpackage
`default_nettype wire

// File: rtl/fft_out_serializer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pair_fifo: DEPTH-entry FIFO of packed sample pairs with occupancy count.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_pair_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Storage is not reset: the pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fft_out_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_out_serializer: buffers Re/Im sample pairs and emits them one sample per beat.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_out_serializer
    import fft_out_serializer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DEPTH     = 8,
    parameter int SKID      = 2,
    parameter int FRAME_LEN = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    input  logic [DATA_W-1:0] io_in_data_0_Re,
    input  logic [DATA_W-1:0] io_in_data_0_Im,
    input  logic [DATA_W-1:0] io_in_data_1_Re,
    input  logic [DATA_W-1:0] io_in_data_1_Im,
    output logic              io_up_en,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_data_Re,
    output logic [DATA_W-1:0] io_out_data_Im,
    output logic              io_out_last,
    output logic              io_overflow
);
    localparam int PAIR_W = 4 * DATA_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  UP_LIMIT = CNT_W'(DEPTH - SKID);
    localparam logic [FCNT_W-1:0] LAST_IDX = FCNT_W'(FRAME_LEN - 1);

    lane_e              state;
    lane_e              state_next;
    logic [PAIR_W-1:0]  wr_pair;
    logic [PAIR_W-1:0]  rd_pair;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               accept;
    logic               drop;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [FCNT_W-1:0]  frame_cnt;
    logic               up_en_q;
    logic               overflow_q;

    assign wr_pair = {io_in_data_0_Re, io_in_data_0_Im, io_in_data_1_Re, io_in_data_1_Im};

    assign io_out_valid = ~empty;
    assign accept       = io_out_valid & io_out_ready;
    assign pop          = accept & (state == LANE1);
    // A full FIFO still takes a pair when the head leaves on the same edge.
    assign push         = io_in_valid & (~full | pop);
    assign drop         = io_in_valid & full & ~pop;
    assign count_next   = count + CNT_W'(push) - CNT_W'(pop);

    fft_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_pair),
        .rd_data (rd_pair),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LANE0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        io_out_data_Re = '0;
        io_out_data_Im = '0;
        if (accept) begin
            state_next = (state == LANE0) ? LANE1 : LANE0;
        end
        if (!empty) begin
            if (state == LANE0) begin
                io_out_data_Re = rd_pair[PAIR_W-1 -: DATA_W];
                io_out_data_Im = rd_pair[PAIR_W-DATA_W-1 -: DATA_W];
            end else begin
                io_out_data_Re = rd_pair[2*DATA_W-1 -: DATA_W];
                io_out_data_Im = rd_pair[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (accept) begin
            frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + FCNT_W'(1);
        end
    end

    // Upstream enable looks at the post-edge occupancy so SKID slots absorb in-flight pairs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_en_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            up_en_q <= (count_next <= UP_LIMIT);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign io_out_last = io_out_valid & (frame_cnt == LAST_IDX);
    assign io_up_en    = up_en_q;
    assign io_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_out_serializer: randomized bench against a queue-based reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_out_serializer;
    import fft_out_serializer_pkg::*;

    localparam int DW        = 32;
    localparam int DEPTH     = 8;
    localparam int SKID      = 2;
    localparam int FRAME_LEN = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_in_valid = 1'b0;
    logic [DW-1:0] io_in_data_0_Re = '0;
    logic [DW-1:0] io_in_data_0_Im = '0;
    logic [DW-1:0] io_in_data_1_Re = '0;
    logic [DW-1:0] io_in_data_1_Im = '0;
    logic          io_up_en;
    logic          io_out_valid;
    logic          io_out_ready = 1'b0;
    logic [DW-1:0] io_out_data_Re;
    logic [DW-1:0] io_out_data_Im;
    logic          io_out_last;
    logic          io_overflow;

    always #5 clock = ~clock;

    fft_out_serializer #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .SKID      (SKID),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_data_0_Re (io_in_data_0_Re),
        .io_in_data_0_Im (io_in_data_0_Im),
        .io_in_data_1_Re (io_in_data_1_Re),
        .io_in_data_1_Im (io_in_data_1_Im),
        .io_up_en        (io_up_en),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_data_Re  (io_out_data_Re),
        .io_out_data_Im  (io_out_data_Im),
        .io_out_last     (io_out_last),
        .io_overflow     (io_overflow)
    );

    // Reference model: queue of pairs, current lane, sample index within frame.
    pair_t       mq[$];
    logic        mlane;
    int          mcnt;
    logic        movf;
    logic        mup;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          beats;
    int          lasts;
    int          last_at;
    logic [63:0] obs_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mlane = 1'b0;
        mcnt  = 0;
        movf  = 1'b0;
        mup   = 1'b0;
    endtask

    task automatic check_outputs();
        logic          v;
        logic [DW-1:0] er;
        logic [DW-1:0] ei;
        v  = (mq.size() > 0);
        er = '0;
        ei = '0;
        if (v) begin
            er = mlane ? mq[0].re1 : mq[0].re0;
            ei = mlane ? mq[0].im1 : mq[0].im0;
        end
        check("out_valid", 64'(io_out_valid), 64'(v));
        check("out_re", 64'(io_out_data_Re), 64'(er));
        check("out_im", 64'(io_out_data_Im), 64'(ei));
        check("out_last", 64'(io_out_last), 64'(v && (mcnt == FRAME_LEN - 1)));
        check("overflow", 64'(io_overflow), 64'(movf));
        check("up_en", 64'(io_up_en), 64'(mup));
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic  acc;
        logic  pop;
        logic  push;
        pair_t p;
        @(negedge clock);
        check_outputs();
        acc = (mq.size() > 0) && io_out_ready;
        if (acc) begin
            beats++;
            obs_q.push_back({io_out_data_Re, io_out_data_Im});
            if (io_out_last) begin
                lasts++;
                last_at = beats;
            end
        end
        pop  = acc && mlane;
        push = io_in_valid && ((mq.size() < DEPTH) || pop);
        p    = {io_in_data_0_Re, io_in_data_0_Im, io_in_data_1_Re, io_in_data_1_Im};
        @(posedge clock);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(p);
        if (io_in_valid && !push) movf = 1'b1;
        if (acc) begin
            mlane = ~mlane;
            mcnt  = (mcnt + 1) % FRAME_LEN;
        end
        mup = (mq.size() <= DEPTH - SKID);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive(input logic v, input pair_t p);
        io_in_valid     = v;
        io_in_data_0_Re = p.re0;
        io_in_data_0_Im = p.im0;
        io_in_data_1_Re = p.re1;
        io_in_data_1_Im = p.im1;
    endtask

    function automatic pair_t rnd_pair();
        pair_t p;
        p.re0 = $urandom;
        p.im0 = $urandom;
        p.re1 = $urandom;
        p.im1 = $urandom;
        return p;
    endfunction

    task automatic drain(input string tag);
        drive(1'b0, rnd_pair());
        io_out_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH + 8 && mq.size() > 0; i++) tick();
        tick();
        check(tag, 64'(io_out_valid), 64'(0));
    endtask

    initial begin
        pair_t p;
        pair_t saved[8];
        logic  up_prev;
        int    sent;
        int    fell_at;
        int    k;

        // Reset state and single pair
        apply_reset();
        p = '{re0: 1, im0: 2, re1: 3, im1: 4};
        drive(1'b1, p);
        io_out_ready = 1'b1;
        tick();
        check("up_en_after_release", 64'(io_up_en), 64'(1));
        drive(1'b0, rnd_pair());
        obs_q.delete();
        tick();
        tick();
        tick();
        check("single_obs_count", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() == 2) begin
            check("single_s0", obs_q[0], {32'd1, 32'd2});
            check("single_s1", obs_q[1], {32'd3, 32'd4});
        end

        // 32 pairs with ready held high, upstream obeying up_en
        apply_reset();
        io_out_ready = 1'b1;
        up_prev = 1'b0;
        sent  = 0;
        beats = 0;
        lasts = 0;
        last_at = 0;
        k = 0;
        while (k < 400 && !(sent == 32 && mq.size() == 0)) begin
            drive(up_prev && (sent < 32), rnd_pair());
            up_prev = io_up_en;
            tick();
            if (io_in_valid) sent++;
            k++;
        end
        check("frame_timeout", 64'(k < 400), 64'(1));
        check("frame_beats", 64'(beats), 64'(64));
        check("frame_lasts", 64'(lasts), 64'(1));
        check("frame_last_at", 64'(last_at), 64'(64));

        // Back-pressure with upstream honouring up_en one register late
        apply_reset();
        io_out_ready = 1'b0;
        up_prev = 1'b0;
        sent    = 0;
        fell_at = -1;
        for (int i = 0; i < 20; i++) begin
            drive(up_prev, rnd_pair());
            up_prev = io_up_en;
            if (!io_up_en && fell_at < 0 && sent > 0) fell_at = sent;
            tick();
            if (io_in_valid) sent++;
        end
        check("bp_fell_at", 64'(fell_at), 64'(7));
        check("bp_sent", 64'(sent), 64'(8));
        check("bp_overflow", 64'(io_overflow), 64'(0));
        drain("bp_drain");

        // Forced input while full: drops but keeps the first 8 pairs
        apply_reset();
        io_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            p = rnd_pair();
            if (i < 8) saved[i] = p;
            drive(1'b1, p);
            tick();
        end
        check("ovf_set", 64'(io_overflow), 64'(1));
        obs_q.delete();
        drain("ovf_drain");
        check("ovf_obs_count", 64'(obs_q.size()), 64'(16));
        if (obs_q.size() == 16) begin
            for (int i = 0; i < 8; i++) begin
                check("ovf_lane0", obs_q[2*i],   {saved[i].re0, saved[i].im0});
                check("ovf_lane1", obs_q[2*i+1], {saved[i].re1, saved[i].im1});
            end
        end

        // Push into a full FIFO on the LANE1 pop edge
        apply_reset();
        io_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rnd_pair());
            tick();
        end
        drive(1'b0, rnd_pair());
        io_out_ready = 1'b1;
        tick();
        p = rnd_pair();
        drive(1'b1, p);
        tick();
        drive(1'b0, rnd_pair());
        io_out_ready = 1'b0;
        tick();
        check("full_pop_ovf", 64'(io_overflow), 64'(0));
        check("full_pop_up_en", 64'(io_up_en), 64'(0));
        obs_q.delete();
        drain("full_pop_drain");
        check("full_pop_count", 64'(obs_q.size()), 64'(16));
        if (obs_q.size() == 16) begin
            check("full_pop_new0", obs_q[14], {p.re0, p.im0});
            check("full_pop_new1", obs_q[15], {p.re1, p.im1});
        end

        // Reset while in LANE1 with 3 pairs buffered
        apply_reset();
        io_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_pair());
            tick();
        end
        drive(1'b0, rnd_pair());
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
        tick();
        apply_reset();
        check("midrst_valid", 64'(io_out_valid), 64'(0));
        tick();
        tick();
        check("midrst_empty", 64'(io_out_valid), 64'(0));
        p = rnd_pair();
        drive(1'b1, p);
        tick();
        obs_q.delete();
        drain("midrst_drain");
        check("midrst_count", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() == 2) begin
            check("midrst_lane0", obs_q[0], {p.re0, p.im0});
        end

        // Random traffic
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_pair());
            io_out_ready = $urandom_range(0, 9) < 6;
            tick();
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of each Re/Im component.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of sample pairs the FIFO holds (power of two).
REQ-003 The block SHALL have parameter SKID, default 2, giving the number of pair slots kept free for upstream in-flight data.
REQ-004 The block SHALL have parameter FRAME_LEN, default 64, giving the number of output samples per frame (even, at least 2).
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port io_in_valid, input, 1 bit: an upstream sample pair is present this cycle.
REQ-008 The block SHALL have ports io_in_data_0_Re, io_in_data_0_Im, io_in_data_1_Re, io_in_data_1_Im, input, DATA_W each: the upstream pair; lane 0 precedes lane 1.
REQ-009 The block SHALL have port io_up_en, output, 1 bit: enable driven to the upstream stage's io_in_en.
REQ-010 The block SHALL have port io_out_valid, output, 1 bit: the serial output sample is valid.
REQ-011 The block SHALL have port io_out_ready, input, 1 bit: the downstream stage accepts the sample.
REQ-012 The block SHALL have ports io_out_data_Re and io_out_data_Im, output, DATA_W each: the serial complex sample.
REQ-013 The block SHALL have port io_out_last, output, 1 bit: marks the final sample of a frame.
REQ-014 The block SHALL have port io_overflow, output, 1 bit: sticky flag indicating a pair was dropped.

Function
REQ-015 A beat SHALL be accepted when io_out_valid and io_out_ready are both 1 in the same cycle.
REQ-016 A push SHALL occur when io_in_valid is 1 and the FIFO is not full, or is full and a pop occurs in the same cycle; the full pair is written as one entry.
REQ-017 A pair arriving on io_in_valid while the FIFO is full with no same-cycle pop SHALL be dropped, SHALL set io_overflow, and SHALL leave FIFO contents unchanged.
REQ-018 A pair pushed at edge N SHALL be presentable on the output from the cycle after edge N (1-cycle latency); empty-FIFO bypass is not provided.
REQ-019 io_out_valid SHALL be 1 whenever the FIFO is non-empty, independent of io_out_ready.
REQ-020 The serializer SHALL be a 2-state FSM: LANE0 presents head lane 0; an accepted beat moves it to LANE1; LANE1 presents head lane 1; an accepted beat pops the head and returns to LANE0.
REQ-021 Output data and FSM state SHALL hold while io_out_valid=1 and io_out_ready=0.
REQ-022 When the FIFO is empty, io_out_data_Re and io_out_data_Im SHALL be driven to 0.
REQ-023 A sample counter SHALL increment on each accepted beat and wrap from FRAME_LEN-1 to 0.
REQ-024 io_out_last SHALL equal io_out_valid AND (counter == FRAME_LEN-1).
REQ-025 The occupancy count SHALL range 0..DEPTH, with read and write pointers wrapping modulo DEPTH; a simultaneous push and pop SHALL leave the count unchanged.
REQ-026 io_up_en SHALL be a register loaded each cycle with (count_next <= DEPTH-SKID).
REQ-027 io_overflow SHALL clear only on reset.

Reset
REQ-028 While reset=0, the FIFO SHALL be emptied, pointers, count and frame counter set to 0, the FSM set to LANE0, and io_out_valid, io_out_last, io_overflow, io_up_en and the output data driven to 0.
REQ-029 io_up_en SHALL rise at the first clock edge after reset release.
REQ-030 A reset asserted mid-frame SHALL discard all buffered data and restart the frame count at 0, with no partial pair emitted afterwards.

Structure
REQ-031 A shared package SHALL hold the DATA_W default, the complex-pair struct {re0, im0, re1, im1}, and the FSM state enum {LANE0, LANE1}.
REQ-032 The FIFO SHALL be a single sub-module named fft_pair_fifo, with push, pop, full, empty and count, parameterized by DEPTH and pair width 4*DATA_W.

Verification
REQ-033 The bench SHALL cover this case: reset release, single pair (1,2),(3,4) pushed, io_out_ready=1 -> io_up_en=1 one edge after release; outputs Re/Im 1/2 then 3/4 on consecutive cycles; then io_out_valid=0.
REQ-034 The bench SHALL cover this case: 32 continuous pairs with io_out_ready=1 and FRAME_LEN=64 -> 64 samples in lane order, io_out_last on sample 64 only, counter back at 0.
REQ-035 The bench SHALL cover this case: io_out_ready=0 while pairs stream in and the upstream model honours io_up_en with 2-cycle latency -> io_up_en falls at count 7, no drop, io_overflow stays 0.
REQ-036 The bench SHALL cover this case: io_out_ready=0 with io_in_valid forced to 1 for 10 cycles -> 8 pairs stored, io_overflow=1, and the first 16 samples drained match the first 8 pairs exactly.
REQ-037 The bench SHALL cover this case: FIFO full, io_in_valid=1 on the same cycle as the LANE1 pop -> new pair accepted, count stays 8, io_overflow stays 0.
REQ-038 The bench SHALL cover this case: reset asserted while in LANE1 with 3 pairs buffered -> io_out_valid=0 immediately, the FIFO is empty after release, and the next pair is emitted from LANE0.
